// File: rtl/sar_cdac_ctrl_if.sv
// Signal bundle between the SAR controller, the comparator/CDAC front-end and the digital back-end.
interface sar_cdac_ctrl_if #(
  parameter int NBIT       = 6,
  parameter int THERM_BITS = 2
);
  // Comparator handshake: cmp_clk is a one-cycle trigger; the comparator answers with a
  // one-cycle cmp_valid strobe carrying cmp, which is only honoured while a decision is awaited.
  logic                         start;
  logic                         cont;
  logic                         cmp;
  logic                         cmp_valid;
  logic                         cmp_clk;
  logic                         sample;
  logic [(1<<THERM_BITS)-2:0]   cbu;
  logic [NBIT-THERM_BITS-1:0]   cb;
  logic [NBIT-1:0]              dout;
  logic                         dvalid;
  logic                         busy;
  logic                         err;

  modport master (
    input  start, cont, cmp, cmp_valid,
    output cmp_clk, sample, cbu, cb, dout, dvalid, busy, err
  );

  modport slave (
    output start, cont, cmp, cmp_valid,
    input  cmp_clk, sample, cbu, cb, dout, dvalid, busy, err
  );
endinterface

// File: rtl/sar_cdac_ctrl.sv
// Successive-approximation controller driving a segmented (unary MSB / binary LSB) capacitor DAC.
module sar_cdac_ctrl #(
  parameter int NBIT       = 6,
  parameter int THERM_BITS = 2,
  parameter int TSAMP      = 2,
  parameter int SETTLE     = 1,
  parameter int TMO_CYC    = 15
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  sar_cdac_ctrl_if.master   bus,
  output logic [2:0]        dbg_state_o
);
  localparam int NU   = (1 << THERM_BITS) - 1;
  localparam int NB   = NBIT - THERM_BITS;
  localparam int CMAX = (TSAMP > SETTLE) ? ((TSAMP > TMO_CYC) ? TSAMP : TMO_CYC)
                                         : ((SETTLE > TMO_CYC) ? SETTLE : TMO_CYC);
  localparam int CW   = $clog2(CMAX + 1);
  localparam int IW   = $clog2(NBIT);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SAMP = 3'd1,
    S_SET  = 3'd2,
    S_FIRE = 3'd3,
    S_WAIT = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [NBIT-1:0]   code_q, code_d;
  logic [NBIT-1:0]   dout_q, dout_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              dvalid_q, dvalid_d;
  logic [NU-1:0]     cbu_q, cbu_d;
  logic [NB-1:0]     cb_q, cb_d;
  logic              resolve;
  logic              bit_val;
  logic [THERM_BITS-1:0] u;

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    dout_d   = dout_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    dvalid_d = 1'b0;
    resolve  = 1'b0;
    bit_val  = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_SAMP;
          code_d  = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      S_SAMP: begin
        if (cnt_q == CW'(TSAMP - 1)) begin
          state_d        = S_SET;
          cnt_d          = '0;
          idx_d          = IW'(NBIT - 1);
          code_d[NBIT-1] = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SET: begin
        if (cnt_q == CW'(SETTLE - 1)) begin
          state_d = S_FIRE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FIRE: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        // A decision arriving on the timeout edge still counts as a real decision.
        if (bus.cmp_valid) begin
          resolve = 1'b1;
          bit_val = ~bus.cmp;
        end else if (cnt_q == CW'(TMO_CYC - 1)) begin
          resolve = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        if (resolve) begin
          code_d[idx_q] = bit_val;
          cnt_d         = '0;
          if (idx_q != '0) begin
            idx_d                 = idx_q - 1'b1;
            code_d[idx_q - 1'b1]  = 1'b1;
            state_d               = S_SET;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        dout_d   = code_q;
        dvalid_d = 1'b1;
        cnt_d    = '0;
        if (bus.cont) begin
          state_d = S_SAMP;
          code_d  = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Array drive is decoded from the next code so it lines up with the internal code register.
  always_comb begin
    u    = code_d[NBIT-1 -: THERM_BITS];
    cb_d = code_d[NB-1:0];
    for (int j = 0; j < NU; j++) begin
      cbu_d[j] = (THERM_BITS'(j) < u);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      code_q   <= '0;
      dout_q   <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      dvalid_q <= 1'b0;
      cbu_q    <= '0;
      cb_q     <= '0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      dout_q   <= dout_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      dvalid_q <= dvalid_d;
      cbu_q    <= cbu_d;
      cb_q     <= cb_d;
    end
  end

  assign bus.sample  = (state_q == S_SAMP);
  assign bus.cmp_clk = (state_q == S_FIRE);
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.cbu     = cbu_q;
  assign bus.cb      = cb_q;
  assign bus.dout    = dout_q;
  assign bus.dvalid  = dvalid_q;
  assign bus.err     = err_q;
  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_sar_cdac_ctrl.sv
// Bench for sar_cdac_ctrl: CDAC/comparator model, arithmetic SAR reference, randomized conversions.
module tb_sar_cdac_ctrl;
  localparam int NBIT   = 6;
  localparam int TB     = 2;
  localparam int NU     = (1 << TB) - 1;
  localparam int NB     = NBIT - TB;
  localparam int TSAMP  = 2;
  localparam int SETTLE = 1;
  localparam int TMO    = 15;
  localparam int BUDGET = 600;

  logic       clk;
  logic       rst_n;
  logic [2:0] dbg_state;

  sar_cdac_ctrl_if #(.NBIT(NBIT), .THERM_BITS(TB)) bus ();

  sar_cdac_ctrl #(
    .NBIT(NBIT), .THERM_BITS(TB), .TSAMP(TSAMP), .SETTLE(SETTLE), .TMO_CYC(TMO)
  ) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .bus(bus),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [NBIT-1:0] exp_q[$];
  int   k_arr[NBIT];     // response delay per bit; 0 = comparator never answers
  bit   dbl_arr[NBIT];   // send a stray second strobe after the real answer
  int   vin;
  int   last_lat;
  logic [NU-1:0] first_cbu;
  logic [NB-1:0] first_cb;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d exp %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int ref_code();
    int code = 0;
    for (int i = NBIT - 1; i >= 0; i--) begin
      int trial = code + (1 << i);
      if (k_arr[i] == 0 || !(trial > vin)) code = trial;
    end
    return code;
  endfunction

  function automatic int ref_lat();
    int s = TSAMP + 1;
    for (int i = 0; i < NBIT; i++) s += SETTLE + 1 + ((k_arr[i] == 0) ? TMO : k_arr[i]);
    return s;
  endfunction

  function automatic bit ref_err();
    bit e = 0;
    for (int i = 0; i < NBIT; i++) if (k_arr[i] == 0) e = 1;
    return e;
  endfunction

  function automatic int dac_level();
    return $countones(bus.cbu) * (1 << NB) + int'(bus.cb);
  endfunction

  task automatic set_k(input int k);
    for (int i = 0; i < NBIT; i++) begin
      k_arr[i]   = k;
      dbl_arr[i] = 1'b0;
    end
  endtask

  // ---------------- driver + comparator model ----------------
  task automatic run(input int n_dv, input int drop_after, input bit hold, input bit stray);
    int  cd, bitn, trial, ndv, t_last, samp_cnt, rc, lat;
    bit  dbl_pend, e_exp;
    cd = -1; bitn = NBIT; ndv = 0; t_last = 0; samp_cnt = 0; dbl_pend = 0; trial = 0;
    rc = ref_code(); lat = ref_lat(); e_exp = ref_err();
    for (int i = 0; i < n_dv; i++) exp_q.push_back(NBIT'(rc));
    bus.start = 1'b1;
    for (int t = 0; t < BUDGET && ndv < n_dv; t++) begin
      @(negedge clk);
      bus.cmp_valid = 1'b0;
      if (t == 0) begin
        if (!hold) bus.start = 1'b0;
        chk("err_clr", 32'(bus.err), 0);
        chk("busy_on", 32'(bus.busy), 1);
      end
      if (bus.dvalid) begin
        last_lat = t - t_last;
        chk("latency", last_lat, lat);
        chk("samp_len", samp_cnt, TSAMP);
        chk("err", 32'(bus.err), 32'(e_exp));
        if (exp_q.size() == 0) chk("dv_extra", 1, 0);
        else chk("dout", 32'(bus.dout), 32'(exp_q.pop_front()));
        if (!bus.busy) begin
          chk("cbu_final", 32'(bus.cbu), (1 << (rc >> NB)) - 1);
          chk("cb_final", 32'(bus.cb), rc % (1 << NB));
        end
        t_last = t; samp_cnt = 0; bitn = NBIT; cd = -1;
        ndv++;
        if (ndv == drop_after) bus.cont = 1'b0;
      end
      if (bus.sample) begin
        samp_cnt++;
        chk("samp_zero", {bus.cbu, bus.cb}, 0);
        if (stray) begin
          bus.cmp_valid = 1'b1;
          bus.cmp = 1'($urandom_range(0, 1));
        end
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          bus.cmp_valid = 1'b1;
          bus.cmp = (trial > vin);
          dbl_pend = dbl_arr[bitn];
        end
      end else if (dbl_pend) begin
        bus.cmp_valid = 1'b1;
        bus.cmp = !(trial > vin);
        dbl_pend = 0;
      end
      if (bus.cmp_clk && bitn > 0) begin
        bitn--;
        trial = dac_level();
        if (bitn == NBIT - 1) begin
          first_cbu = bus.cbu;
          first_cb  = bus.cb;
        end
        cd = k_arr[bitn];
      end
    end
    if (ndv < n_dv) chk("dv_timeout", ndv, n_dv);
    bus.start = 1'b0;
    bus.cmp_valid = 1'b0;
    exp_q.delete();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pulses, dv_seen, r;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.cont = 1'b0; bus.cmp = 1'b0; bus.cmp_valid = 1'b0;
    last_lat = 0;
    idle(2);
    chk("rst_outs", {bus.sample, bus.cmp_clk, bus.cbu, bus.cb, bus.dout, bus.dvalid, bus.busy, bus.err}, 0);
    rst_n = 1'b1;
    idle(2);

    // directed: target 37, k=1
    vin = 37; set_k(1);
    run(1, -1, 0, 0);
    chk("t1_lat", last_lat, 21);
    chk("t1_dout", 32'(bus.dout), 6'b100101);
    chk("t1_first_cbu", 32'(first_cbu), 3'b011);
    chk("t1_first_cb", 32'(first_cb), 4'b0000);
    idle(3);

    // extremes
    vin = -1; run(1, -1, 0, 0);
    chk("t2_zero", 32'(bus.dout), 0);
    idle(2);
    vin = 63; run(1, -1, 0, 0);
    chk("t2_full", 32'(bus.dout), 63);
    chk("t2_cbu", 32'(bus.cbu), 3'b111);
    chk("t2_cb", 32'(bus.cb), 4'b1111);
    idle(2);

    // comparator never answers
    vin = 20; set_k(0);
    run(1, -1, 0, 0);
    chk("t3_lat", last_lat, TSAMP + NBIT * (SETTLE + 1 + TMO) + 1);
    idle(5);
    chk("t3_err_sticky", 32'(bus.err), 1);

    // continuous mode, dropped during the third conversion
    vin = 10; set_k(1);
    bus.cont = 1'b1;
    run(3, 2, 0, 0);
    chk("t4_busy_off", 32'(bus.busy), 0);
    dv_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.dvalid) dv_seen++;
    end
    chk("t4_no_extra_dv", dv_seen, 0);

    // reset during WAIT of bit 3
    vin = 45; set_k(0);
    pulses = 0;
    bus.start = 1'b1;
    for (int t = 0; t < 200 && pulses < 3; t++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.cmp_clk) pulses++;
    end
    chk("t5_reached_bit3", pulses, 3);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("t5_async_zero", {bus.sample, bus.cmp_clk, bus.cbu, bus.cb, bus.dout, bus.dvalid, bus.busy, bus.err}, 0);
    dv_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.dvalid) dv_seen++;
    end
    chk("t5_no_dv", dv_seen, 0);
    rst_n = 1'b1;
    idle(2);
    vin = 29; set_k(2);
    run(1, -1, 0, 0);

    // start held, stray strobes, decision coincident with the timeout edge
    vin = 50; set_k(1);
    k_arr[4] = TMO; k_arr[1] = TMO;
    dbl_arr[5] = 1; dbl_arr[3] = 1; dbl_arr[0] = 1;
    run(1, -1, 1, 1);
    chk("t6_dout", 32'(bus.dout), 50);
    chk("t6_no_err", 32'(bus.err), 0);
    idle(3);
    chk("t6_idle", 32'(bus.busy), 0);

    // randomized conversions
    for (int n = 0; n < 14; n++) begin
      vin = $urandom_range(0, (1 << NBIT) - 1);
      for (int i = 0; i < NBIT; i++) begin
        r = $urandom_range(0, 9);
        k_arr[i]   = (r == 0) ? 0 : (r == 1) ? TMO : $urandom_range(1, 4);
        dbl_arr[i] = 1'($urandom_range(0, 1));
      end
      run(1, -1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      idle($urandom_range(1, 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sar_cdac_ctrl.md
Name: sar_cdac_ctrl

Overview:
- Parametrised successive-approximation controller that drives the bottom-plate code of a segmented capacitor DAC array.
- Top THERM_BITS of the code are thermometer-decoded onto unary capacitor groups. The remaining LSBs drive binary-weighted groups directly.
- Sequences track/sample, per-bit settle, comparator trigger/acknowledge handshake, and result hand-off.
- Supports single-shot and continuous conversion, plus a comparator-timeout error flag.
- Sits between the CDAC array (CT node into comparator) and the digital back-end.

Parameters:
NBIT, 6, total conversion resolution in bits (3..12)
THERM_BITS, 2, MSBs thermometer-decoded to unary groups (1..NBIT-1)
TSAMP, 2, cycles SAMPLE held high (>=1)
SETTLE, 1, cycles trial code is applied before comparator trigger (>=1)
TMO_CYC, 15, max cycles waiting for CMP_VALID after CMP_CLK (>=1)

Ports:
CLK  in  1  clock
RST_N  in  1  asynchronous active-low reset
START  in  1  level; sampled in IDLE to begin a conversion
CONT  in  1  continuous mode; re-sampled in DONE
CMP  in  1  comparator decision; 1 = trial too high, clear the bit
CMP_VALID  in  1  comparator result strobe
CMP_CLK  out  1  one-cycle comparator trigger
SAMPLE  out  1  top-plate track switch enable
CBU  out  2^THERM_BITS-1  unary group drive (thermometer)
CB  out  NBIT-THERM_BITS  binary group drive, LSB at bit 0
DOUT  out  NBIT  last completed conversion code
DVALID  out  1  one-cycle pulse when DOUT updates
BUSY  out  1  high from SAMPLE through DONE
ERR  out  1  sticky comparator-timeout flag

Behaviour:
- Reset (async, RST_N=0):
  - state=IDLE; all outputs 0.
  - Internal code, bit index, and counters cleared.
  - Reset mid-conversion aborts immediately; no DVALID is issued.
- States: IDLE, SAMP, SET, FIRE, WAIT, DONE.
- IDLE:
  - START=1 at an edge -> SAMP; code<=0; ERR<=0; BUSY<=1.
  - START is ignored in every other state.
- SAMP:
  - SAMPLE=1 for exactly TSAMP cycles; CBU/CB=0.
  - Then -> SET with bit index i=NBIT-1 and code[i]<=1.
- SET:
  - Trial code drives CBU/CB for SETTLE cycles, then -> FIRE.
- FIRE:
  - CMP_CLK=1 for one cycle, then -> WAIT; timeout counter cleared.
- WAIT, on CMP_VALID=1:
  - code[i]<=~CMP.
  - If i>0: i--, set code[i-1]=1, -> SET.
  - If i=0: -> DONE.
- WAIT, timeout:
  - Timeout when TMO_CYC cycles elapse with no CMP_VALID.
  - Bit is kept (treated as CMP=0); ERR<=1 (sticky); continue as above.
  - CMP_VALID in the same cycle as the timeout wins; ERR is not set.
- CMP_VALID outside WAIT is ignored.
- DONE:
  - DOUT<=code; DVALID=1 for one cycle.
  - If CONT=1 -> SAMP (BUSY stays 1, ERR retained).
  - Else -> IDLE, BUSY<=0.
  - CONT dropped mid-conversion lets the current conversion finish, then returns to IDLE.
- Output decode (registered from code):
  - Let u = code[NBIT-1:NBIT-THERM_BITS]; CBU[j]=1 iff j<u.
  - CB = code[NBIT-THERM_BITS-1:0].
- Latency with comparator response k cycles after CMP_CLK:
  - DVALID occurs TSAMP + NBIT*(SETTLE+1+k) + 1 cycles after the START-sampling edge.
  - Defaults with k=1: 21 cycles.
- DOUT holds its value until the next DONE.

Test Plan:
1. Defaults; comparator model CMP=(trial>37), k=1; START pulse -> DVALID at cycle 21; DOUT=6'b100101. During the first trial, CBU=3'b011 and CB=4'b0000. Final CBU=3'b011, CB=4'b0101.
2. Extremes: model CMP=1 always -> DOUT=0; CMP=0 always -> DOUT=63 with CBU=3'b111, CB=4'b1111. ERR=0 in both.
3. Never assert CMP_VALID -> each bit times out after 15 cycles; DOUT=63; ERR=1 until the next START from IDLE.
4. CONT=1 with model target 10 -> back-to-back DVALID pulses 21 cycles apart, each DOUT=10. Drop CONT mid-conversion -> one more DVALID, then BUSY=0.
5. Assert RST_N=0 during WAIT of bit 3 -> all outputs 0 asynchronously; no DVALID. After release, the next START converts correctly.
6. START held high throughout; CMP_VALID pulsed in SET/SAMP; CMP_VALID coincident with the timeout edge -> stray strobes ignored, no ERR, DOUT unaffected.
